// File: rtl/gate_vector_checker.sv
// gate_vector_checker
//
// Stimulus/response engine for a single-output combinational (or shallowly
// registered) gate block. A sweep drives every N_IN-bit vector onto vec_out,
// holds it for SETTLE cycles, then samples dut_y for one CHECK cycle and
// compares it against the truth table latched when the sweep was started.
// At the end of the sweep a one-cycle done pulse is raised together with
// final pass / err_count / first_fail_vec results, which are then held until
// the next accepted start.
//
// Optional build macro:
//   GATE_CHK_STOP_ON_FAIL_EN - when defined, the first mismatching CHECK ends
//                              the sweep immediately (err_count = 1).
//
// Cycle timing (start sampled high in cycle 0):
//   vector k driven   : cycles k*(SETTLE+1)+1 .. k*(SETTLE+1)+SETTLE
//   vector k sampled  : cycle (k+1)*(SETTLE+1)
//   done              : cycle 2^N_IN*(SETTLE+1)+1 (or earlier when stopping)

module gate_vector_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [(1 << N_IN)-1:0]   truth_table,
    output logic [N_IN-1:0]          vec_out,
    input  logic                     dut_y,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [N_IN:0]            err_count,
    output logic [N_IN-1:0]          first_fail_vec
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int NUM_VEC = 1 << N_IN;
    localparam int ERR_W   = N_IN + 1;
    // Settle counter only needs to reach SETTLE-1; keep at least one bit.
    localparam int CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [N_IN-1:0]  LAST_VEC    = {N_IN{1'b1}};
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  VEC_ZERO    = {N_IN{1'b0}};
    localparam logic [N_IN-1:0]  VEC_ONE     = N_IN'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [ERR_W-1:0] ERR_ZERO    = {ERR_W{1'b0}};
    localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
    localparam logic STOP_ON_FAIL = 1'b1;
`else
    localparam logic STOP_ON_FAIL = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_r;
    logic [CNT_W-1:0]       settle_cnt_r;
    logic [NUM_VEC-1:0]     tt_r;

    logic                   expected_s;
    logic                   mismatch_s;
    logic                   last_vec_s;
    logic                   end_sweep_s;
    logic                   first_mismatch_s;
    logic [ERR_W-1:0]       err_next_s;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Look up the expected gate output for one vector index.
    function automatic logic tt_lookup(
        input logic [NUM_VEC-1:0] table_bits,
        input logic [N_IN-1:0]    idx
    );
        tt_lookup = table_bits[idx];
    endfunction

    // Saturating-free increment of the mismatch counter; the counter can
    // reach at most 2^N_IN, which always fits in N_IN+1 bits.
    function automatic logic [ERR_W-1:0] err_add(
        input logic [ERR_W-1:0] cnt,
        input logic             inc
    );
        if (inc) begin
            err_add = cnt + ERR_ONE;
        end else begin
            err_add = cnt;
        end
    endfunction

    // ------------------------------------------------------------------
    // Compare logic for the CHECK cycle
    // ------------------------------------------------------------------

    // Evaluate the sampled output against the latched table and decide
    // whether this CHECK cycle finishes the sweep.
    always_comb begin
        expected_s       = 1'b0;
        mismatch_s       = 1'b0;
        last_vec_s       = 1'b0;
        end_sweep_s      = 1'b0;
        first_mismatch_s = 1'b0;
        err_next_s       = err_count;

        expected_s = tt_lookup(tt_r, vec_out);
        last_vec_s = (vec_out == LAST_VEC);

        if (state_r == ST_CHECK) begin
            mismatch_s = (dut_y != expected_s);
        end else begin
            mismatch_s = 1'b0;
        end

        // The first mismatch is the one seen while the counter is still zero.
        if (mismatch_s && (err_count == ERR_ZERO)) begin
            first_mismatch_s = 1'b1;
        end else begin
            first_mismatch_s = 1'b0;
        end

        err_next_s = err_add(err_count, mismatch_s);

        if (last_vec_s || (STOP_ON_FAIL && mismatch_s)) begin
            end_sweep_s = 1'b1;
        end else begin
            end_sweep_s = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sweep controller with registered outputs
    // ------------------------------------------------------------------

    // Sequence IDLE -> (DRIVE x SETTLE -> CHECK) per vector -> DONE -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            settle_cnt_r   <= CNT_ZERO;
            tt_r           <= {NUM_VEC{1'b0}};
            vec_out        <= VEC_ZERO;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= ERR_ZERO;
            first_fail_vec <= VEC_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Accept a new sweep: restart from vector 0 and
                        // clear the results of the previous sweep.
                        state_r        <= ST_DRIVE;
                        settle_cnt_r   <= CNT_ZERO;
                        tt_r           <= truth_table;
                        vec_out        <= VEC_ZERO;
                        busy           <= 1'b1;
                        pass           <= 1'b0;
                        err_count      <= ERR_ZERO;
                        first_fail_vec <= VEC_ZERO;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_DRIVE: begin
                    // Hold the vector for SETTLE cycles before sampling.
                    if (settle_cnt_r == SETTLE_LAST) begin
                        state_r <= ST_CHECK;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + CNT_ONE;
                        state_r      <= ST_DRIVE;
                    end
                end

                ST_CHECK: begin
                    err_count <= err_next_s;
                    if (first_mismatch_s) begin
                        first_fail_vec <= vec_out;
                    end else begin
                        first_fail_vec <= first_fail_vec;
                    end

                    if (end_sweep_s) begin
                        // Results are made final here so they are already
                        // valid in the cycle that carries the done pulse.
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_next_s == ERR_ZERO);
                    end else begin
                        state_r      <= ST_DRIVE;
                        vec_out      <= vec_out + VEC_ONE;
                        settle_cnt_r <= CNT_ZERO;
                    end
                end

                ST_DONE: begin
                    // vec_out is intentionally left at its last value.
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end

                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Self-checking bench for gate_vector_checker.
// Two checker instances (SETTLE=2 and SETTLE=1) each face a small gate model
// (OR / AND / XOR / registered OR). A table of sweeps is applied; the
// expected sweep results are queued when start is driven and popped when the
// selected instance raises done. Hand-written sequences cover mid-sweep
// reset and start re-assertion while busy.

module tb_gate_vector_checker;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0;
    logic       start1;
    logic [3:0] tt;
    int         mode;

    logic [1:0] vec0, vec1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [2:0] err0, err1;
    logic [1:0] ff0, ff1;
    logic       y0, y1, yreg0, yreg1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         sel;       // 0: SETTLE=2 instance, 1: SETTLE=1 instance
        int         mode;      // 0 OR, 1 AND, 2 XOR, 3 registered OR
        logic [3:0] tt;
        logic [2:0] err;
        logic [1:0] first;
        logic       pass;
        int         done_cyc;
    } vec_t;

    vec_t tbl[8];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    // Gate under test models: one register stage for the registered OR.
    always_ff @(posedge clk) begin
        yreg0 <= |vec0;
        yreg1 <= |vec1;
    end

    function automatic logic gate(input int m, input logic [1:0] v, input logic r);
        case (m)
            0:       gate = |v;
            1:       gate = &v;
            2:       gate = ^v;
            3:       gate = r;
            default: gate = 1'b0;
        endcase
    endfunction

    assign y0 = gate(mode, vec0, yreg0);
    assign y1 = gate(mode, vec1, yreg1);

    gate_vector_checker #(.N_IN(N), .SETTLE(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .truth_table(tt),
        .vec_out(vec0), .dut_y(y0), .busy(busy0), .done(done0),
        .pass(pass0), .err_count(err0), .first_fail_vec(ff0)
    );

    gate_vector_checker #(.N_IN(N), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .truth_table(tt),
        .vec_out(vec1), .dut_y(y1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .first_fail_vec(ff1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int sel, input int m, input logic [3:0] t,
                                input logic [2:0] e, input logic [1:0] f,
                                input logic p, input int dc);
        vec_t v;
        v.sel = sel; v.mode = m; v.tt = t; v.err = e; v.first = f;
        v.pass = p; v.done_cyc = dc;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one sweep; optional extra start pulses at cycles xa / xb (-1: none).
    task automatic run_sweep(input vec_t v, input int xa, input int xb);
        int   s;
        int   c;
        bit   seen;
        vec_t e;
        logic cb, cd, cp;
        logic [1:0] cv, cf;
        logic [2:0] ce;
        s = (v.sel == 1) ? 1 : 2;
        tt = v.tt;
        mode = v.mode;
        if (v.sel == 1) start1 = 1'b1; else start0 = 1'b1;
        exp_q.push_back(v);
        step();
        start0 = 1'b0;
        start1 = 1'b0;
        seen = 1'b0;
        for (int cc = 1; cc <= 60 && !seen; cc++) begin
            c  = cc;
            start0 = 1'b0;
            start1 = 1'b0;
            cb = (v.sel == 1) ? busy1 : busy0;
            cd = (v.sel == 1) ? done1 : done0;
            cp = (v.sel == 1) ? pass1 : pass0;
            cv = (v.sel == 1) ? vec1  : vec0;
            cf = (v.sel == 1) ? ff1   : ff0;
            ce = (v.sel == 1) ? err1  : err0;
            if (c == xa || c == xb) begin
                if (v.sel == 1) start1 = 1'b1; else start0 = 1'b1;
            end
            if (cd === 1'b1) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", c, e.done_cyc);
                    chk("err_count", ce, e.err);
                    chk("first_fail_vec", cf, e.first);
                    chk("pass", cp, e.pass);
                    chk("busy_in_done", cb, 1'b0);
                    chk("vec_in_done", cv, (e.done_cyc - 2) / (s + 1));
                end
            end else if (c < v.done_cyc) begin
                chk("busy_sweep", cb, 1'b1);
                chk("vec_sweep", cv, (c - 1) / (s + 1));
            end
            if (!seen) step();
        end
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            // Results and vec_out are held after the pulse; start in DONE is ignored.
            for (int k = 0; k < 3; k++) begin
                step();
                start0 = 1'b0;
                start1 = 1'b0;
                chk("done_after", (v.sel == 1) ? done1 : done0, 1'b0);
                chk("busy_after", (v.sel == 1) ? busy1 : busy0, 1'b0);
                chk("vec_held", (v.sel == 1) ? vec1 : vec0, (v.done_cyc - 2) / (s + 1));
                chk("pass_held", (v.sel == 1) ? pass1 : pass0, v.pass);
                chk("err_held", (v.sel == 1) ? err1 : err0, v.err);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        rst_n  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        tt     = 4'b0000;
        mode   = 0;

        tbl[0] = mk(0, 0, 4'b1110, 3'd0, 2'd0, 1'b1, 13);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        tbl[1] = mk(0, 1, 4'b1110, 3'd1, 2'd1, 1'b0, 7);
        tbl[3] = mk(0, 0, 4'b0000, 3'd1, 2'd1, 1'b0, 7);
        tbl[4] = mk(0, 1, 4'b0111, 3'd1, 2'd0, 1'b0, 4);
        tbl[7] = mk(1, 1, 4'b1110, 3'd1, 2'd1, 1'b0, 5);
`else
        tbl[1] = mk(0, 1, 4'b1110, 3'd2, 2'd1, 1'b0, 13);
        tbl[3] = mk(0, 0, 4'b0000, 3'd3, 2'd1, 1'b0, 13);
        tbl[4] = mk(0, 1, 4'b0111, 3'd4, 2'd0, 1'b0, 13);
        tbl[7] = mk(1, 1, 4'b1110, 3'd2, 2'd1, 1'b0, 9);
`endif
        tbl[2] = mk(0, 2, 4'b0110, 3'd0, 2'd0, 1'b1, 13);
        tbl[5] = mk(0, 3, 4'b1110, 3'd0, 2'd0, 1'b1, 13);
        tbl[6] = mk(1, 3, 4'b1110, 3'd0, 2'd0, 1'b1, 9);

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vec", vec0, 2'd0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_pass", pass0, 1'b0);
        chk("rst_err", err0, 3'd0);
        chk("rst_ff", ff0, 2'd0);
        @(negedge clk) rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_sweep(tbl[i], -1, -1);
        end

        // Mid-sweep reset at cycle 5: immediate return to reset values, no done.
        tt = 4'b1110;
        mode = 0;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat (4) step();
        chk("pre_rst_vec", vec0, 2'd1);
        chk("pre_rst_busy", busy0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vec", vec0, 2'd0);
        chk("mid_rst_busy", busy0, 1'b0);
        chk("mid_rst_done", done0, 1'b0);
        chk("mid_rst_pass", pass0, 1'b0);
        chk("mid_rst_err", err0, 3'd0);
        chk("mid_rst_ff", ff0, 2'd0);
        @(negedge clk) rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (done0 === 1'b1) dn++;
        end
        chk("no_done_after_rst", dn, 0);
        chk("idle_after_rst", busy0, 1'b0);
        run_sweep(tbl[0], -1, -1);

        // start re-asserted at cycles 3 and 13 is ignored.
        run_sweep(tbl[0], 3, 13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
